// File: rtl/vc_test_rand_delay_unordered_source_pkg.sv
// vc_test_src_pkg: shared FSM states, LFSR taps and window limit for the unordered source
package vc_test_src_pkg;
  typedef enum logic [1:0] {ST_DELAY, ST_SEND, ST_DONE} state_e;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int MAX_WINDOW = 8;
endpackage

// File: rtl/vc_test_rand_delay_unordered_source_if.sv
// vc_test_rand_delay_unordered_source_if: val/rdy message stream plus done flag
interface vc_test_rand_delay_unordered_source_if #(parameter int p_msg_nbits = 8);
  logic val;
  logic rdy;
  logic done;
  logic [p_msg_nbits-1:0] msg;
  modport master (output val, msg, done, input rdy);
  modport slave (input val, msg, done, output rdy);
endinterface

// File: rtl/vc_test_rand_delay_unordered_source_lfsr.sv
// vc_lfsr32: free-running 32-bit Galois LFSR (taps 32,22,2,1), reloads seed on reset
module vc_lfsr32
  import vc_test_src_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] seed,
  output logic [31:0] out
);
  // advance once per cycle, unconditionally
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) out <= seed;
    else out <= (out >> 1) ^ (out[0] ? LFSR_TAPS : 32'd0);
endmodule

// File: rtl/vc_test_rand_delay_unordered_source.sv
// vc_test_rand_delay_unordered_source: random-delay, window-reordered message source; VC_TEST_UNORDERED_SRC_INORDER_EN forces window 1
module vc_test_rand_delay_unordered_source
  import vc_test_src_pkg::*;
#(
  parameter int          p_msg_nbits = 8,
  parameter int          p_num_msgs  = 1024,
  parameter int          p_window    = 4,
  parameter logic [31:0] p_seed      = 32'hB1A5_ED01
)(
  input logic        clk,
  input logic        reset_n,
  input logic [31:0] max_delay,
  input logic [31:0] num_msgs,
  vc_test_rand_delay_unordered_source_if.master src
);
`ifdef VC_TEST_UNORDERED_SRC_INORDER_EN
  localparam int W = 1;
`else
  localparam int W = (p_window > MAX_WINDOW) ? MAX_WINDOW : p_window;
`endif
  localparam int IW = $clog2(p_num_msgs);
  localparam int AW = IW + 1;
  logic [p_msg_nbits-1:0] m [p_num_msgs] = '{default: '0};
  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d, lfsr, ediv;
  logic [AW-1:0] base_q, base_d, sel_q, sel_d, sent_q, sent_d, num_eff, pick;
  logic [W-1:0] mask_q, mask_d, mask_or, elig;
  logic [3:0] ecnt, kth, seen;
  logic [32:0] draw;
  logic xfer, last;
  vc_lfsr32 u_lfsr (.clk(clk), .reset_n(reset_n), .seed(p_seed), .out(lfsr));
  assign num_eff = (num_msgs > 32'(p_num_msgs)) ? AW'(p_num_msgs) : num_msgs[AW-1:0];
  assign xfer    = (state_q == ST_SEND) && src.rdy;
  assign last    = sent_q == num_eff - 1'b1;
  assign draw    = {1'b0, lfsr} % ({1'b0, max_delay} + 33'd1);
  assign mask_or = mask_q | (xfer ? W'(1) << (sel_q - base_q) : '0);
  assign base_d  = base_q + AW'(mask_or[0]);
  assign mask_d  = mask_or[0] ? mask_or >> 1 : mask_or;
  assign ediv    = {28'd0, (ecnt == 4'd0) ? 4'd1 : ecnt};
  assign kth     = 4'(lfsr % ediv);
  assign src.val  = state_q == ST_SEND;
  assign src.done = state_q == ST_DONE;
  assign src.msg  = src.val ? m[sel_q[IW-1:0]] : '0;
  // choose among unsent in-range entries of the window as it will look next cycle,
  // so a freshly sent base entry never leaves the window looking full
  always_comb begin
    elig = '0;
    ecnt = '0;
    seen = '0;
    pick = base_d;
    for (int i = 0; i < W; i++) begin
      elig[i] = !mask_d[i] && (base_d + AW'(i) < num_eff);
      ecnt = ecnt + 4'(elig[i]);
    end
    for (int i = 0; i < W; i++)
      if (elig[i]) begin
        if (seen == kth) pick = base_d + AW'(i);
        seen = seen + 4'd1;
      end
  end
  // next state; cnt holds remaining idle cycles minus one so a zero draw skips DELAY entirely
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    sent_d  = sent_q + AW'(xfer);
    case (state_q)
      ST_DELAY:
        if (num_eff == '0) state_d = ST_DONE;
        else if (cnt_q != '0) cnt_d = cnt_q - 32'd1;
        else if (ecnt != '0) begin
          state_d = ST_SEND;
          sel_d   = pick;
        end
      ST_SEND:
        if (xfer) begin
          if (last) state_d = ST_DONE;
          else if (draw == '0) sel_d = pick;
          else begin
            state_d = ST_DELAY;
            cnt_d   = draw[31:0] - 32'd1;
          end
        end
      default: ;
    endcase
  end
  // state registers; reset abandons any in-flight transfer
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_DELAY;
      cnt_q   <= '0;
      base_q  <= '0;
      mask_q  <= '0;
      sel_q   <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      sent_q  <= sent_d;
    end
endmodule
